// File: rtl/sort_stream_loader.sv
// Stream front/back end for the sorting core: loads a frame through WrInit, runs the sort,
// then drains the RAM in address order. Define SORT_LOADER_PAD_EN to allow short frames (padded with all-ones).
module sort_stream_loader #(
   parameter int N     = 8,
   parameter int L     = 4,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_last,
   output logic         busy,
   output logic         srt_wr_init,
   output logic         srt_rd,
   output logic [L-1:0] srt_addr,
   output logic [N-1:0] srt_data_in,
   output logic         srt_start,
   input  logic [N-1:0] srt_data_out,
   input  logic         srt_done
);

   localparam logic [L:0] DEPTH_C = (L+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_LOAD  = 3'd0,
`ifdef SORT_LOADER_PAD_EN
      S_PAD   = 3'd1,
`endif
      S_START = 3'd2,
      S_SORT  = 3'd3,
      S_RD    = 3'd4,
      S_CAP   = 3'd5,
      S_OUT   = 3'd6
   } state_t;

   state_t       state, state_nxt;
   logic [L:0]   wr_idx, rd_idx, count;
   logic         wr_q;
   logic [L-1:0] wr_addr_q;
   logic [N-1:0] wr_data_q;
   logic [N-1:0] out_data_r;
   logic         out_last_r;
   logic         seen_low;
   logic         frame_full;

   assign frame_full = (wr_idx == DEPTH_C - 1'b1);

`ifdef SORT_LOADER_PAD_EN
   logic [L:0] count_r;
   assign count = count_r;
`else
   logic unused_in_last;
   assign unused_in_last = in_last;
   assign count = DEPTH_C;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_LOAD: begin
`ifdef SORT_LOADER_PAD_EN
            if (in_valid && (frame_full || in_last))
               state_nxt = frame_full ? S_START : S_PAD;
`else
            if (in_valid && frame_full)
               state_nxt = S_START;
`endif
         end
`ifdef SORT_LOADER_PAD_EN
         S_PAD:   if (frame_full) state_nxt = S_START;
`endif
         // hold off start until the final registered write has reached the RAM
         S_START: if (!wr_q) state_nxt = S_SORT;
         S_SORT:  if (srt_done && seen_low) state_nxt = S_RD;
         S_RD:    state_nxt = S_CAP;
         S_CAP:   state_nxt = S_OUT;
         S_OUT:   if (out_ready) state_nxt = out_last_r ? S_LOAD : S_RD;
         default: state_nxt = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_LOAD;
         wr_idx     <= '0;
         rd_idx     <= '0;
         wr_q       <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         out_data_r <= '0;
         out_last_r <= 1'b0;
         seen_low   <= 1'b0;
`ifdef SORT_LOADER_PAD_EN
         count_r    <= '0;
`endif
      end else begin
         state <= state_nxt;
         wr_q  <= 1'b0;
         case (state)
            S_LOAD: if (in_valid) begin
               wr_q      <= 1'b1;
               wr_addr_q <= wr_idx[L-1:0];
               wr_data_q <= in_data;
               wr_idx    <= wr_idx + 1'b1;
`ifdef SORT_LOADER_PAD_EN
               count_r   <= wr_idx + 1'b1;
`endif
            end
`ifdef SORT_LOADER_PAD_EN
            S_PAD: begin
               wr_q      <= 1'b1;
               wr_addr_q <= wr_idx[L-1:0];
               wr_data_q <= '1;
               wr_idx    <= wr_idx + 1'b1;
            end
`endif
            // done must be seen low after start before its rise counts
            S_START: seen_low <= !wr_q && !srt_done;
            S_SORT:  if (!srt_done) seen_low <= 1'b1;
            S_CAP: begin
               out_data_r <= srt_data_out;
               out_last_r <= (rd_idx == count - 1'b1);
            end
            S_OUT: if (out_ready) begin
               if (out_last_r) begin
                  wr_idx     <= '0;
                  rd_idx     <= '0;
                  out_last_r <= 1'b0;
`ifdef SORT_LOADER_PAD_EN
                  count_r    <= '0;
`endif
               end else begin
                  rd_idx <= rd_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready    = rst_n && (state == S_LOAD);
   assign out_valid   = (state == S_OUT);
   assign out_data    = out_data_r;
   assign out_last    = (state == S_OUT) && out_last_r;
   assign busy        = !((state == S_LOAD) && (wr_idx == '0));
   assign srt_wr_init = wr_q;
   assign srt_rd      = (state == S_RD);
   assign srt_addr    = wr_q ? wr_addr_q : ((state == S_RD) ? rd_idx[L-1:0] : '0);
   assign srt_data_in = wr_q ? wr_data_q : '0;
   assign srt_start   = (state == S_SORT) || ((state == S_START) && !wr_q);

endmodule
